// File: rtl/pipeline_stage_reg.sv
// -----------------------------------------------------------------------------
// pipeline_stage_reg
//
// Reusable register between two pipeline stages. It carries a packed payload
// under valid/ready flow control. It supports a synchronous flush, which
// inserts a bubble, and an optional 2-entry skid buffer. With the skid buffer
// enabled, oReady comes straight from a flop, so there is no combinational
// path from iReady to oReady.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high on that link. The input side fires on iValid && oReady, and the output
// side fires on oValid && iReady. While oValid is high and iReady is low, the
// stage holds oValid and oData unchanged. A producer may drop iValid or change
// iData freely while oReady is low.
//
// Parameters
//   WIDTH    payload width in bits (>= 1)
//   SKID     1: two entries, registered oReady; 0: one entry, combinational oReady
//   RST_VAL  value that oData takes on reset and on flush
//
// Ports
//   iClk        clock, rising edge
//   iRstN       asynchronous active-low reset
//   iFlush      synchronous flush; drops every held entry and the incoming one
//   iValid      upstream payload present on iData
//   oReady      stage can accept this cycle
//   iData       upstream payload
//   oValid      oData holds a valid payload
//   iReady      downstream accepts this cycle
//   oData       payload to the downstream stage
//   oOccupancy  number of entries held (0, 1 or 2)
//   oDbgState   current FSM state (EMPTY=0, BUSY=1, FULL=2) for checkers
// -----------------------------------------------------------------------------
module pipeline_stage_reg #(
    parameter int unsigned      WIDTH   = 32,
    parameter bit               SKID    = 1'b1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             iClk,
    input  logic             iRstN,
    input  logic             iFlush,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iData,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oData,
    output logic [1:0]       oOccupancy,
    output logic [1:0]       oDbgState
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q,  main_d;   // output register, always the oldest entry
    logic [WIDTH-1:0] skid_q,  skid_d;   // overflow register, used only in FULL
    logic             ready_q, ready_d;  // registered oReady for the skid variant
    logic             in_fire;
    logic             out_fire;

    assign oValid    = (state_q != ST_EMPTY);
    assign oData     = main_q;
    assign oDbgState = state_q;

    // The single-entry variant can accept new data in the same cycle that the
    // current entry leaves. That is why its oReady has to look at iReady.
    assign oReady   = SKID ? ready_q : (!oValid || iReady);
    assign in_fire  = iValid && oReady;
    assign out_fire = oValid && iReady;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (iFlush) begin
            state_d = ST_EMPTY;
            main_d  = RST_VAL;
            skid_d  = RST_VAL;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_BUSY;
                        main_d  = iData;
                    end
                end
                ST_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d = iData;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end else if (in_fire && SKID) begin
                        // Downstream stalled while upstream still pushed, so
                        // park the new payload behind the one on oData.
                        state_d = ST_FULL;
                        skid_d  = iData;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d = ST_BUSY;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
        // Ready for next cycle is derived from the next state, so the flop
        // always agrees with the state register.
        ready_d = (state_d != ST_FULL);
    end

    always_comb begin
        oOccupancy = 2'd0;
        case (state_q)
            ST_EMPTY: oOccupancy = 2'd0;
            ST_BUSY:  oOccupancy = 2'd1;
            ST_FULL:  oOccupancy = 2'd2;
            default:  oOccupancy = 2'd0;
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= ST_EMPTY;
            main_q  <= RST_VAL;
            skid_q  <= RST_VAL;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end

    // A stalled output must not move unless the stage is being flushed.
    stall_stable_a: assert property (@(posedge iClk) disable iff (!iRstN)
        (oValid && !iReady && !iFlush) |=> (oValid && $stable(oData)));

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stage_reg
//
// Drives one SKID=1 instance and one SKID=0 instance with identical inputs.
// Each instance is compared against its own reference FIFO: a queue that
// holds at most two entries (skid) or one entry (single). Transfers are
// applied at each rising edge using the handshake rules.
// -----------------------------------------------------------------------------
module tb_pipeline_stage_reg;

    localparam int          W    = 16;
    localparam logic [W-1:0] RSTV = 16'hDEAD;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // shared stimulus
    logic         flush;
    logic         valid;
    logic         in_rdy;
    logic [W-1:0] data;

    // skid instance outputs
    logic         rdy1, vld1;
    logic [W-1:0] dout1;
    logic [1:0]   occ1, st1;
    // single-entry instance outputs
    logic         rdy0, vld0;
    logic [W-1:0] dout0;
    logic [1:0]   occ0, st0;

    pipeline_stage_reg #(.WIDTH(W), .SKID(1'b1), .RST_VAL(RSTV)) dut1 (
        .iClk(clk), .iRstN(rst_n), .iFlush(flush), .iValid(valid), .oReady(rdy1),
        .iData(data), .oValid(vld1), .iReady(in_rdy), .oData(dout1),
        .oOccupancy(occ1), .oDbgState(st1)
    );

    pipeline_stage_reg #(.WIDTH(W), .SKID(1'b0), .RST_VAL(RSTV)) dut0 (
        .iClk(clk), .iRstN(rst_n), .iFlush(flush), .iValid(valid), .oReady(rdy0),
        .iData(data), .oValid(vld0), .iReady(in_rdy), .oData(dout0),
        .oOccupancy(occ0), .oDbgState(st0)
    );

    // scoreboard
    logic [W-1:0] exp_q1[$];
    logic [W-1:0] exp_q0[$];
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_state();
        chk("skid_valid", 32'(vld1), 32'(exp_q1.size() > 0));
        chk("skid_occ",   32'(occ1), 32'(exp_q1.size()));
        if (exp_q1.size() > 0) chk("skid_data", 32'(dout1), 32'(exp_q1[0]));
        chk("single_valid", 32'(vld0), 32'(exp_q0.size() > 0));
        chk("single_occ",   32'(occ0), 32'(exp_q0.size()));
        if (exp_q0.size() > 0) chk("single_data", 32'(dout0), 32'(exp_q0[0]));
    endtask

    // One cycle: called at a falling edge. It drives inputs, checks oReady,
    // applies the transfers at the rising edge and checks the result at the
    // next falling edge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        logic acc1, acc0, pop1, pop0;
        valid  = v;
        data   = d;
        in_rdy = r;
        flush  = f;
        #1;
        acc1 = v && (exp_q1.size() < 2);
        acc0 = v && (exp_q0.size() == 0 || r);
        pop1 = r && (exp_q1.size() > 0);
        pop0 = r && (exp_q0.size() > 0);
        chk("skid_ready",   32'(rdy1), 32'(exp_q1.size() < 2));
        chk("single_ready", 32'(rdy0), 32'(exp_q0.size() == 0 || r));
        @(posedge clk);
        if (f) begin
            exp_q1.delete();
            exp_q0.delete();
        end else begin
            if (pop1) void'(exp_q1.pop_front());
            if (acc1) exp_q1.push_back(d);
            if (pop0) void'(exp_q0.pop_front());
            if (acc0) exp_q0.push_back(d);
        end
        @(negedge clk);
        check_state();
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_skid_valid"},   32'(vld1),  32'd0);
        chk({tag, "_skid_occ"},     32'(occ1),  32'd0);
        chk({tag, "_skid_data"},    32'(dout1), 32'(RSTV));
        chk({tag, "_skid_ready"},   32'(rdy1),  32'd1);
        chk({tag, "_single_valid"}, 32'(vld0),  32'd0);
        chk({tag, "_single_occ"},   32'(occ0),  32'd0);
        chk({tag, "_single_data"},  32'(dout0), 32'(RSTV));
        chk({tag, "_single_ready"}, 32'(rdy0),  32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rp;
        rst_n  = 1'b0;
        flush  = 1'b0;
        valid  = 1'b0;
        in_rdy = 1'b0;
        data   = '0;
        repeat (2) @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;

        // Reset in the middle of traffic: fill the stage, then reset asynchronously.
        step(1'b1, 16'h0011, 1'b0, 1'b0);
        step(1'b1, 16'h0022, 1'b0, 1'b0);
        chk("t1_skid_occ_full", 32'(occ1), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("t1_async");
        exp_q1.delete();
        exp_q0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 16'h0033, 1'b1, 1'b0);
        chk("t1_first_after_rst", 32'(dout1), 32'h0033);
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Back-to-back streaming with no backpressure.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, W'(i), 1'b1, 1'b0);
            chk("t2_stream_data", 32'(dout1), 32'(i));
        end
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Backpressure fills the skid buffer, then the stage drains in order.
        step(1'b1, 16'h000A, 1'b0, 1'b0);
        step(1'b1, 16'h000B, 1'b0, 1'b0);
        chk("t3_occ_full", 32'(occ1), 32'd2);
        chk("t3_not_ready", 32'(rdy1), 32'd0);
        step(1'b1, 16'h000C, 1'b0, 1'b0);
        step(1'b1, 16'h000C, 1'b1, 1'b0);
        chk("t3_second_out", 32'(dout1), 32'h000B);
        step(1'b1, 16'h000C, 1'b1, 1'b0);
        chk("t3_third_out", 32'(dout1), 32'h000C);
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Flush while full, with an input arriving in the same cycle.
        step(1'b1, 16'h0001, 1'b0, 1'b0);
        step(1'b1, 16'h0002, 1'b0, 1'b0);
        step(1'b1, 16'h000D, 1'b0, 1'b1);
        check_cleared("t4_flush");
        step(1'b1, 16'h000E, 1'b1, 1'b0);
        chk("t4_after_flush", 32'(dout1), 32'h000E);
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Single-entry variant: ready follows iReady in the same cycle.
        step(1'b1, 16'h0050, 1'b1, 1'b0);
        step(1'b1, 16'h0060, 1'b0, 1'b0);
        chk("t5_single_stalled", 32'(dout0), 32'h0050);
        step(1'b1, 16'h0070, 1'b1, 1'b0);
        chk("t5_single_replaced", 32'(dout0), 32'h0070);
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Random traffic, with the backpressure level changing in phases.
        rp = 50;
        for (int i = 0; i < 10000; i++) begin
            if (i % 500 == 0) rp = $urandom_range(10, 95);
            step(1'($urandom_range(0, 1)), W'($urandom),
                 1'($urandom_range(0, 99) < rp), 1'($urandom_range(0, 63) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
